// File: rtl/mips_pkg.sv
// Shared types and constants for the MIPS fetch stage.
// Holds the fetch FSM encoding and the default fetch words.
package mips_pkg;

    typedef enum logic [1:0] {
        FC_BOOT,
        FC_RUN,
        FC_HALT
    } fc_state_t;

    localparam logic [31:0] HALT_WORD_DEFAULT = 32'hFFFF_FFFF;
    localparam logic [31:0] RESET_PC_DEFAULT  = 32'h0000_0000;
    localparam logic [31:0] NOP_WORD          = 32'h0000_0000;

    function automatic logic [31:0] word_align(input logic [31:0] a);
        return {a[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_ctrl_if.sv
// Loader, instruction-memory and decode-side signals of fetch_ctrl.
// slave is the controller's view, master the environment's view.
interface fetch_ctrl_if #(
    parameter int AW = 5
);
    logic          load_valid;
    logic          load_ready;
    logic [AW-1:0] load_addr;
    logic [31:0]   load_data;
    logic          load_done;
    logic          stall;
    logic          redirect_valid;
    logic [31:0]   redirect_target;
    logic          imem_we;
    logic [AW-1:0] imem_waddr;
    logic [31:0]   imem_wdata;
    logic [AW-1:0] imem_raddr;
    logic [31:0]   imem_rdata;
    logic [31:0]   pc;
    logic [31:0]   instr;
    logic [31:0]   instr_pc;
    logic          instr_valid;
    logic          halted;

    modport slave (
        input  load_valid, load_addr, load_data, load_done,
        input  stall, redirect_valid, redirect_target, imem_rdata,
        output load_ready, imem_we, imem_waddr, imem_wdata,
        output imem_raddr, pc, instr, instr_pc, instr_valid, halted
    );

    modport master (
        output load_valid, load_addr, load_data, load_done,
        output stall, redirect_valid, redirect_target, imem_rdata,
        input  load_ready, imem_we, imem_waddr, imem_wdata,
        input  imem_raddr, pc, instr, instr_pc, instr_valid, halted
    );

endinterface

// File: rtl/fetch_pc_next.sv
// Next-PC mux: a redirect wins over hold, hold wins over +4.
// Redirect targets are forced onto a word boundary.
module fetch_pc_next
    import mips_pkg::*;
(
    input  logic [31:0] pc_i,
    input  logic        redirect_i,
    input  logic [31:0] target_i,
    input  logic        hold_i,
    output logic [31:0] pc_next_o
);

    // Select the next fetch address.
    always_comb begin
        pc_next_o = pc_i + 32'd4;
        if (redirect_i) begin
            pc_next_o = word_align(target_i);
        end else if (hold_i) begin
            pc_next_o = pc_i;
        end
    end

endmodule

// File: rtl/fetch_ctrl.sv
// Fetch-stage controller: boot loading, PC sequencing, stall,
// redirect and halt handling in front of the decode stage.
module fetch_ctrl
    import mips_pkg::*;
#(
    parameter int          IMEM_DEPTH = 32,
    parameter logic [31:0] RESET_PC   = RESET_PC_DEFAULT,
    parameter logic [31:0] HALT_WORD  = HALT_WORD_DEFAULT
) (
    input logic          clk,
    input logic          reset,
    fetch_ctrl_if.slave  bus
);

    localparam int AW = $clog2(IMEM_DEPTH);

    fc_state_t   state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] instr_pc_q, instr_pc_d;
    logic        valid_q, valid_d;
    logic        redir;
    logic        adv;
    logic        we;
    logic        is_halt;

    assign is_halt = (bus.imem_rdata == HALT_WORD);

    fetch_pc_next u_pc_next (
        .pc_i      (pc_q),
        .redirect_i(redir),
        .target_i  (bus.redirect_target),
        .hold_i    (!adv),
        .pc_next_o (pc_d)
    );

    // Next state and fetch-register updates; a redirect beats stall.
    always_comb begin
        state_d    = state_q;
        instr_d    = instr_q;
        instr_pc_d = instr_pc_q;
        valid_d    = valid_q;
        redir      = 1'b0;
        adv        = 1'b0;
        we         = 1'b0;
        unique case (state_q)
            FC_BOOT: begin
                we      = bus.load_valid;
                valid_d = 1'b0;
                if (bus.load_done) begin
                    state_d = FC_RUN;
                end
            end
            FC_RUN: begin
                if (bus.redirect_valid) begin
                    redir   = 1'b1;
                    valid_d = 1'b0;
                    instr_d = NOP_WORD;
                end else if (!bus.stall) begin
                    instr_d    = bus.imem_rdata;
                    instr_pc_d = pc_q;
                    valid_d    = 1'b1;
                    if (is_halt) begin
                        state_d = FC_HALT;
                    end else begin
                        adv = 1'b1;
                    end
                end
            end
            FC_HALT: begin
                if (bus.redirect_valid) begin
                    redir   = 1'b1;
                    state_d = FC_RUN;
                    valid_d = 1'b0;
                    instr_d = NOP_WORD;
                end else if (!bus.stall) begin
                    valid_d = 1'b0;
                end
            end
            default: begin
                state_d = FC_BOOT;
            end
        endcase
    end

    // State and fetch registers, cleared asynchronously by reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= FC_BOOT;
            pc_q       <= RESET_PC;
            instr_q    <= NOP_WORD;
            instr_pc_q <= 32'h0;
            valid_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            instr_q    <= instr_d;
            instr_pc_q <= instr_pc_d;
            valid_q    <= valid_d;
        end
    end

    assign bus.load_ready  = (state_q == FC_BOOT);
    assign bus.imem_we     = we;
    assign bus.imem_waddr  = bus.load_addr;
    assign bus.imem_wdata  = bus.load_data;
    assign bus.imem_raddr  = pc_q[AW+1:2];
    assign bus.pc          = pc_q;
    assign bus.instr       = instr_q;
    assign bus.instr_pc    = instr_pc_q;
    assign bus.instr_valid = valid_q;
    assign bus.halted      = (state_q == FC_HALT);

endmodule

// File: tb/tb_fetch_ctrl.sv
// Self-checking bench for fetch_ctrl with a behavioural memory
// and a scoreboard of expected {instr_pc, instr} deliveries.
module tb_fetch_ctrl;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] w;
    } exp_t;

    localparam logic [31:0] HALTW = 32'hFFFF_FFFF;

    logic clk;
    logic reset;
    int   tests;
    int   fails;
    exp_t sb[$];

    logic [31:0] mem [32];

    fetch_ctrl_if #(.AW(5)) bus ();

    fetch_ctrl #(
        .IMEM_DEPTH(32),
        .RESET_PC  (32'h0),
        .HALT_WORD (HALTW)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (bus.imem_we) mem[bus.imem_waddr] <= bus.imem_wdata;
    end
    assign bus.imem_rdata = mem[bus.imem_raddr];

    // One clock: score any delivery at the negedge, then step past posedge.
    task automatic cyc();
        exp_t e;
        @(negedge clk);
        if (!reset && bus.instr_valid && !bus.stall) begin
            tests++;
            if (sb.size() == 0) begin
                fails++;
                $display("FAIL sb_extra: got pc=%h instr=%h, required none",
                         bus.instr_pc, bus.instr);
            end else begin
                e = sb.pop_front();
                if (bus.instr_pc !== e.pc || bus.instr !== e.w) begin
                    fails++;
                    $display("FAIL sb_deliver: got pc=%h instr=%h, required pc=%h instr=%h",
                             bus.instr_pc, bus.instr, e.pc, e.w);
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bus.load_valid = 1'b0;
        bus.load_addr = '0;
        bus.load_data = '0;
        bus.load_done = 1'b0;
        bus.stall = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.redirect_target = '0;
        repeat (2) @(posedge clk);
        #1;
        tests++;
        if (bus.pc !== 32'h0 || bus.instr !== 32'h0 || bus.instr_pc !== 32'h0) begin
            fails++;
            $display("FAIL reset_regs: got pc=%h instr=%h ipc=%h, required 0 0 0",
                     bus.pc, bus.instr, bus.instr_pc);
        end
        tests++;
        if (bus.instr_valid !== 1'b0 || bus.halted !== 1'b0 || bus.load_ready !== 1'b1) begin
            fails++;
            $display("FAIL reset_flags: got v=%b h=%b lr=%b, required 0 0 1",
                     bus.instr_valid, bus.halted, bus.load_ready);
        end
        reset = 1'b0;
    endtask

    task automatic test_boot_load();
        logic [4:0]  a [7];
        logic [31:0] d [7];
        a = '{5'd0, 5'd1, 5'd2, 5'd3, 5'd4, 5'd5, 5'd31};
        d = '{32'h0, 32'h20080005, 32'h20090006, HALTW,
              32'hABCD0004, 32'hABCD0005, 32'hABCD001F};
        for (int i = 0; i < 7; i++) begin
            bus.load_valid = 1'b1;
            bus.load_addr = a[i];
            bus.load_data = d[i];
            bus.load_done = (i == 6);
            #1;
            tests++;
            if (bus.imem_we !== 1'b1 || bus.load_ready !== 1'b1 ||
                bus.imem_waddr !== a[i] || bus.imem_wdata !== d[i]) begin
                fails++;
                $display("FAIL boot_write%0d: got we=%b lr=%b a=%h d=%h, required 1 1 %h %h",
                         i, bus.imem_we, bus.load_ready, bus.imem_waddr,
                         bus.imem_wdata, a[i], d[i]);
            end
            cyc();
        end
        bus.load_addr = 5'd0;
        bus.load_data = 32'hDEADBEEF;
        bus.load_done = 1'b0;
        #1;
        tests++;
        if (bus.load_ready !== 1'b0 || bus.imem_we !== 1'b0) begin
            fails++;
            $display("FAIL run_drop_write: got lr=%b we=%b, required 0 0",
                     bus.load_ready, bus.imem_we);
        end
        tests++;
        if (bus.instr_valid !== 1'b0 || bus.pc !== 32'h0) begin
            fails++;
            $display("FAIL boot_nofetch: got v=%b pc=%h, required 0 0",
                     bus.instr_valid, bus.pc);
        end
        sb.push_back('{32'h0, 32'h0});
        sb.push_back('{32'h4, 32'h20080005});
        sb.push_back('{32'h8, 32'h20090006});
        sb.push_back('{32'hC, HALTW});
        cyc();
        bus.load_valid = 1'b0;
        tests++;
        if (bus.instr_valid !== 1'b1 || bus.instr_pc !== 32'h0 || bus.pc !== 32'h4) begin
            fails++;
            $display("FAIL first_fetch: got v=%b ipc=%h pc=%h, required 1 0 4",
                     bus.instr_valid, bus.instr_pc, bus.pc);
        end
        cyc();
        tests++;
        if (bus.instr_pc !== 32'h4 || bus.pc !== 32'h8) begin
            fails++;
            $display("FAIL second_fetch: got ipc=%h pc=%h, required 4 8",
                     bus.instr_pc, bus.pc);
        end
    endtask

    task automatic test_stall();
        bus.stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cyc();
            tests++;
            if (bus.instr_pc !== 32'h4 || bus.instr !== 32'h20080005 ||
                bus.pc !== 32'h8 || bus.instr_valid !== 1'b1) begin
                fails++;
                $display("FAIL stall_hold%0d: got ipc=%h instr=%h pc=%h v=%b, required 4 20080005 8 1",
                         i, bus.instr_pc, bus.instr, bus.pc, bus.instr_valid);
            end
        end
        bus.stall = 1'b0;
        cyc();
        tests++;
        if (bus.instr_pc !== 32'h8 || bus.pc !== 32'hC) begin
            fails++;
            $display("FAIL stall_resume: got ipc=%h pc=%h, required 8 c",
                     bus.instr_pc, bus.pc);
        end
    endtask

    task automatic test_halt();
        cyc();
        tests++;
        if (bus.instr !== HALTW || bus.instr_valid !== 1'b1 ||
            bus.halted !== 1'b1 || bus.pc !== 32'hC) begin
            fails++;
            $display("FAIL halt_deliver: got instr=%h v=%b h=%b pc=%h, required ffffffff 1 1 c",
                     bus.instr, bus.instr_valid, bus.halted, bus.pc);
        end
        cyc();
        tests++;
        if (bus.instr_valid !== 1'b0 || bus.halted !== 1'b1 || bus.pc !== 32'hC) begin
            fails++;
            $display("FAIL halt_idle: got v=%b h=%b pc=%h, required 0 1 c",
                     bus.instr_valid, bus.halted, bus.pc);
        end
        cyc();
        tests++;
        if (bus.pc !== 32'hC || bus.imem_raddr !== 5'd3) begin
            fails++;
            $display("FAIL halt_frozen: got pc=%h ra=%h, required c 3",
                     bus.pc, bus.imem_raddr);
        end
        bus.redirect_valid = 1'b1;
        bus.redirect_target = 32'h0;
        cyc();
        bus.redirect_valid = 1'b0;
        tests++;
        if (bus.halted !== 1'b0 || bus.pc !== 32'h0 || bus.instr_valid !== 1'b0) begin
            fails++;
            $display("FAIL halt_resume: got h=%b pc=%h v=%b, required 0 0 0",
                     bus.halted, bus.pc, bus.instr_valid);
        end
        sb.push_back('{32'h0, 32'h0});
        sb.push_back('{32'h4, 32'h20080005});
        sb.push_back('{32'h8, 32'h20090006});
        sb.push_back('{32'hC, HALTW});
        repeat (4) cyc();
        tests++;
        if (bus.halted !== 1'b1 || bus.instr_pc !== 32'hC) begin
            fails++;
            $display("FAIL rehalt: got h=%b ipc=%h, required 1 c",
                     bus.halted, bus.instr_pc);
        end
        cyc();
    endtask

    task automatic test_redirect_stall();
        bus.redirect_valid = 1'b1;
        bus.redirect_target = 32'h0000_0013;
        bus.stall = 1'b1;
        cyc();
        bus.redirect_valid = 1'b0;
        bus.stall = 1'b0;
        tests++;
        if (bus.pc !== 32'h10 || bus.instr_valid !== 1'b0 || bus.halted !== 1'b0) begin
            fails++;
            $display("FAIL redir_bubble: got pc=%h v=%b h=%b, required 10 0 0",
                     bus.pc, bus.instr_valid, bus.halted);
        end
        sb.push_back('{32'h10, 32'hABCD0004});
        cyc();
        tests++;
        if (bus.instr_pc !== 32'h10 || bus.instr_valid !== 1'b1 || bus.pc !== 32'h14) begin
            fails++;
            $display("FAIL redir_target: got ipc=%h v=%b pc=%h, required 10 1 14",
                     bus.instr_pc, bus.instr_valid, bus.pc);
        end
    endtask

    task automatic test_wrap();
        bus.redirect_valid = 1'b1;
        bus.redirect_target = 32'h7C;
        cyc();
        bus.redirect_valid = 1'b0;
        tests++;
        if (bus.pc !== 32'h7C || bus.imem_raddr !== 5'd31 || bus.instr_valid !== 1'b0) begin
            fails++;
            $display("FAIL wrap_start: got pc=%h ra=%h v=%b, required 7c 1f 0",
                     bus.pc, bus.imem_raddr, bus.instr_valid);
        end
        sb.push_back('{32'h7C, 32'hABCD001F});
        sb.push_back('{32'h80, 32'h0});
        cyc();
        tests++;
        if (bus.pc !== 32'h80 || bus.imem_raddr !== 5'd0) begin
            fails++;
            $display("FAIL wrap_raddr: got pc=%h ra=%h, required 80 0",
                     bus.pc, bus.imem_raddr);
        end
        cyc();
        cyc();
    endtask

    task automatic test_reset_mid();
        #3;
        reset = 1'b1;
        #1;
        tests++;
        if (bus.pc !== 32'h0 || bus.instr !== 32'h0 || bus.instr_pc !== 32'h0 ||
            bus.instr_valid !== 1'b0) begin
            fails++;
            $display("FAIL midreset_regs: got pc=%h instr=%h ipc=%h v=%b, required 0 0 0 0",
                     bus.pc, bus.instr, bus.instr_pc, bus.instr_valid);
        end
        tests++;
        if (bus.halted !== 1'b0 || bus.load_ready !== 1'b1) begin
            fails++;
            $display("FAIL midreset_flags: got h=%b lr=%b, required 0 1",
                     bus.halted, bus.load_ready);
        end
        cyc();
        reset = 1'b0;
        bus.load_valid = 1'b1;
        bus.load_addr = 5'd9;
        bus.load_data = 32'h1234_5678;
        #1;
        tests++;
        if (bus.imem_we !== 1'b1 || bus.load_ready !== 1'b1) begin
            fails++;
            $display("FAIL midreset_boot: got we=%b lr=%b, required 1 1",
                     bus.imem_we, bus.load_ready);
        end
        bus.load_valid = 1'b0;
        bus.load_done = 1'b1;
        cyc();
        bus.load_done = 1'b0;
        tests++;
        if (bus.instr_valid !== 1'b0 || bus.load_ready !== 1'b0) begin
            fails++;
            $display("FAIL reboot_run: got v=%b lr=%b, required 0 0",
                     bus.instr_valid, bus.load_ready);
        end
        sb.push_back('{32'h0, 32'h0});
        sb.push_back('{32'h4, 32'h20080005});
        cyc();
        cyc();
        cyc();
    endtask

    initial begin
        tests = 0;
        fails = 0;
        test_reset();
        test_boot_load();
        test_stall();
        test_halt();
        test_redirect_stall();
        test_wrap();
        test_reset_mid();
        tests++;
        if (sb.size() != 0) begin
            fails++;
            $display("FAIL sb_leftover: got %0d pending, required 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
